// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - segment type, blank pattern and hex font shared by the display driver
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} font for one hex nibble.
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_driver_if.sv
// rtl/hex_display_driver_if.sv - value/control inputs and static/scanned segment outputs of the display driver
interface hex_display_driver_if
  import hex_display_pkg::*;
#(
  parameter int DIGITS = 6
);

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blank_lz;
  logic [DIGITS-1:0]     blink_mask;
  logic [7*DIGITS-1:0]   hex_static;
  seg_t                  scan_seg;
  logic [DIGITS-1:0]     scan_sel;

  modport master (
    output load, value, blank_lz, blink_mask,
    input  hex_static, scan_seg, scan_sel
  );

  modport slave (
    input  load, value, blank_lz, blink_mask,
    output hex_static, scan_seg, scan_sel
  );

endinterface

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational nibble to active-low segment decoder
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - multi-digit hex display with leading-zero blanking, blinking and static/scanned outputs
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
)(
  input  logic                 clk,
  input  logic                 reset,
  hex_display_driver_if.slave  bus
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;
  logic [7*DIGITS-1:0] hex_static_q, hex_static_d;
  seg_t                scan_seg_q, scan_seg_d;
  logic [DIGITS-1:0]   scan_sel_q, scan_sel_d;

  seg_t                dec [DIGITS];
  logic [DIGITS-1:0]   upper_zero;
  logic [DIGITS-1:0]   digit_blank;
  logic                blink_wrap;
  logic                scan_wrap;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hex_seg_decode u_dec (
      .nibble_i (value_q[4*g +: 4]),
      .seg_o    (dec[g])
    );
  end

  always_comb begin
    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;

    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_wrap) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end

    value_d = bus.load ? bus.value : value_q;
  end

  // upper_zero[i]: nibble i and every nibble above it are zero.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run           = run & (value_q[4*i +: 4] == 4'h0);
      upper_zero[i] = run;
    end
  end

  always_comb begin
    digit_blank  = '0;
    hex_static_d = '1;
    scan_seg_d   = SEG_BLANK;
    scan_sel_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      digit_blank[i] = ((i != 0) && bus.blank_lz && upper_zero[i]) ||
                       (blink_phase_q && bus.blink_mask[i]);
      hex_static_d[7*i +: 7] = digit_blank[i] ? SEG_BLANK : dec[i];
    end
    // Scan outputs come from the same next-state slice so seg and sel never skew.
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == scan_idx_q) begin
        scan_seg_d    = hex_static_d[7*i +: 7];
        scan_sel_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_cnt_q    <= '0;
      scan_idx_q    <= '0;
      hex_static_q  <= '1;
      scan_seg_q    <= SEG_BLANK;
      scan_sel_q    <= '1;
    end else begin
      value_q       <= value_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_cnt_q    <= scan_cnt_d;
      scan_idx_q    <= scan_idx_d;
      hex_static_q  <= hex_static_d;
      scan_seg_q    <= scan_seg_d;
      scan_sel_q    <= scan_sel_d;
    end
  end

  assign bus.hex_static = hex_static_q;
  assign bus.scan_seg   = scan_seg_q;
  assign bus.scan_sel   = scan_sel_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - randomized self-checking bench for hex_display_driver against a cycle-count reference model
module tb_hex_display_driver;

  localparam int DIGITS    = 6;
  localparam int BLINK_DIV = 4;
  localparam int SCAN_DIV  = 2;

  logic clk;
  logic reset;

  hex_display_driver_if #(.DIGITS(DIGITS)) dif ();

  hex_display_driver #(
    .DIGITS    (DIGITS),
    .BLINK_DIV (BLINK_DIV),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stored value plus number of non-reset edges since the last reset.
  logic [4*DIGITS-1:0] mv;
  int                  t;
  logic [7*DIGITS-1:0] exp_static;
  logic [6:0]          exp_seg;
  logic [DIGITS-1:0]   exp_sel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7*DIGITS-1:0] model_static(input logic [4*DIGITS-1:0] v, input int tc,
                                                       input logic blz, input logic [DIGITS-1:0] mask);
    logic [7*DIGITS-1:0] s;
    logic                hidden;
    int                  phase;
    phase = (tc / BLINK_DIV) % 2;
    for (int i = 0; i < DIGITS; i++) begin
      hidden = (blz && i > 0 && (v >> (4*i)) == 0) || (phase == 1 && mask[i]);
      s[7*i +: 7] = hidden ? 7'h7F : font[v[4*i +: 4]];
    end
    return s;
  endfunction

  task automatic step();
    int idx;
    @(posedge clk);
    if (reset) begin
      exp_static = '1;
      exp_seg    = 7'h7F;
      exp_sel    = '1;
      mv         = '0;
      t          = 0;
    end else begin
      exp_static = model_static(mv, t, dif.blank_lz, dif.blink_mask);
      idx        = (t / SCAN_DIV) % DIGITS;
      exp_seg    = exp_static[7*idx +: 7];
      exp_sel    = ~(DIGITS'(1) << idx);
      if (dif.load) mv = dif.value;
      t++;
    end
    #1;
    check("hex_static", 64'(dif.hex_static), 64'(exp_static));
    check("scan_seg",   64'(dif.scan_seg),   64'(exp_seg));
    check("scan_sel",   64'(dif.scan_sel),   64'(exp_sel));
  endtask

  initial begin
    logic [31:0] r;
    int          nz;
    bit          found;

    mv = '0;
    t  = 0;
    reset          = 1'b1;
    dif.load       = 1'b1;
    dif.value      = 24'h123456;
    dif.blank_lz   = 1'b0;
    dif.blink_mask = '0;

    // Reset dominates load.
    repeat (3) step();
    check("reset_blank", 64'(dif.hex_static), 64'({DIGITS{7'h7F}}));
    reset    = 1'b0;
    dif.load = 1'b0;
    step();
    check("no_capture", 64'(dif.hex_static), 64'({DIGITS{7'h40}}));

    dif.load  = 1'b1;
    dif.value = 24'h00A0F1;
    step();
    dif.load = 1'b0;
    step();
    check("load_a0f1", 64'(dif.hex_static), 64'({7'h40, 7'h40, 7'h08, 7'h40, 7'h0E, 7'h79}));

    dif.blank_lz = 1'b1;
    step();
    check("lz_a0f1", 64'(dif.hex_static), 64'({7'h7F, 7'h7F, 7'h08, 7'h40, 7'h0E, 7'h79}));
    dif.load  = 1'b1;
    dif.value = '0;
    step();
    dif.load = 1'b0;
    step();
    check("lz_zero", 64'(dif.hex_static), 64'({{5{7'h7F}}, 7'h40}));

    dif.blank_lz = 1'b0;
    dif.load     = 1'b1;
    dif.value    = 24'h000001;
    step();
    dif.load       = 1'b0;
    dif.blink_mask = 6'b000001;
    repeat (16) step();

    dif.blink_mask = '0;
    repeat (14) step();

    // Reset mid-scan at digit 3.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (exp_sel == 6'h37) found = 1'b1;
    end
    check("reach_idx3", 64'(found), 64'(1));
    reset = 1'b1;
    step();
    check("mid_rst_sel", 64'(dif.scan_sel), 64'(6'h3F));
    check("mid_rst_seg", 64'(dif.scan_seg), 64'(7'h7F));
    reset = 1'b0;
    step();
    check("restart_sel", 64'(dif.scan_sel), 64'(6'h3E));
    repeat (10) step();

    for (int k = 0; k < 400; k++) begin
      r  = $urandom;
      nz = $urandom_range(0, DIGITS);
      reset          = ($urandom_range(0, 39) == 0);
      dif.load       = ($urandom_range(0, 3) == 0);
      dif.value      = 24'(r & ((32'h1 << (4*nz)) - 1));
      dif.blank_lz   = 1'($urandom_range(0, 1));
      dif.blink_mask = DIGITS'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
